// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
// Contents: rx_state_t FSM encoding, DATA_BITS frame width, IDLE_LEVEL line idle value.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_receive_if.sv
// uart_receive_if: received-byte bundle from the UART receiver to its consumer.
// master: receiver drives rxdata/rxvalid/rxbusy/framing_err/parity_err; slave: consumer reads them.
interface uart_receive_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rxdata;
  logic                 rxvalid;
  logic                 rxbusy;
  logic                 framing_err;
  logic                 parity_err;

  modport master (
    output rxdata,
    output rxvalid,
    output rxbusy,
    output framing_err,
    output parity_err
  );

  modport slave (
    input rxdata,
    input rxvalid,
    input rxbusy,
    input framing_err,
    input parity_err
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports: clock, reset (sync, active-high), d_i async input, q_o synced output; RESET_VAL sets reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver, mid-bit sampling, LSB first, one-cycle strobes.
// Ports: clock, reset (sync, active-high), rx serial pin, rx_if (master) byte/status bundle.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx,
  uart_receive_if.master rx_if
);

  localparam int HALF_BIT = CLOCKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLOCKS_PER_BIT) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic rxs;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
  logic                 rxvalid_q, rxvalid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 par_bad;

  sync_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;

  always_ff @(posedge clock) begin
    if (reset) par_bad_q <= 1'b0;
    else       par_bad_q <= par_bad_d;
  end

  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rxs != IDLE_LEVEL) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // a start bit that is gone by mid-bit was a glitch
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          if (bit_q == IDX_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rxs ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // leave at mid-stop so a back-to-back start edge is seen
          state_d = IDLE;
          if (!rxs) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (par_bad) begin
            perr_d = 1'b1;
          end else begin
            rxvalid_d = 1'b1;
            rxdata_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_if.rxdata      = rxdata_q;
  assign rx_if.rxvalid     = rxvalid_q;
  assign rx_if.rxbusy      = (state_q != IDLE);
  assign rx_if.framing_err = ferr_q;
  assign rx_if.parity_err  = perr_q;

endmodule
